// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: opcodes, mux selects,
// ALU op codes and the state encoding that debug/trace logic also decodes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Encodings are pinned because trace tooling decodes the raw 4-bit value.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_FAULT     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       retire;
  } ctrl_t;

  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Control bundle between the main control FSM (master) and the multi-cycle datapath (slave).
interface mips_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic             fault;
  logic             instr_retired;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, fault, instr_retired, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, fault, instr_retired, instr_count
  );
endinterface

// File: rtl/multicycle_main_control_mem_wait_timer.sv
// Consecutive memory-wait cycle counter; expire fires in the cycle that would
// be the WAIT_MAX-th consecutive wait.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] TC = 8'(WAIT_MAX - 1);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign expire = enable && (wait_cnt == TC);

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath with memory-wait trap and retire counter.
//  state     | meaning
//  IDLE      | one cycle after reset before first fetch
//  FETCH     | read instruction at PC, PC += 4 when memory is ready
//  DECODE    | precompute branch target, dispatch on opcode
//  MEM_ADDR  | compute lw/sw effective address
//  MEM_RD    | load data read, waits for mem_ready
//  MEM_WB    | write loaded data to rt
//  MEM_WR    | store data write, waits for mem_ready
//  R_EXEC    | R-type ALU operation
//  R_WB      | write ALU result to rd
//  BRANCH    | beq compare and conditional PC load
//  JUMP      | PC load from jump target
//  ADDI_EXEC | immediate add
//  ADDI_WB   | write ALU result to rt
//  FAULT     | memory timeout trap, held until reset
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst_n,
  mips_ctrl_if.master bus
);

  state_t           state, state_nxt;
  ctrl_t            ctrl;
  logic             timer_en;
  logic             timer_clr;
  logic             timer_expire;
  logic [CNT_W-1:0] instr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Any cycle that is not a stalled memory access restarts the timeout window.
  assign timer_en  = is_wait_state(state) && !bus.mem_ready;
  assign timer_clr = !timer_en;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clr),
    .enable (timer_en),
    .expire (timer_expire)
  );

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_nxt = S_DECODE;
        end else if (timer_expire) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH;
        ctrl.alu_op    = ALU_OP_ADD;
        case (bus.opcode)
          OP_RTYPE:     state_nxt = S_R_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDI_EXEC;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_nxt       = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_nxt      = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.mem_ready) begin
          state_nxt = S_MEM_WB;
        end else if (timer_expire) begin
          state_nxt = S_FAULT;
        end
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (bus.mem_ready) begin
          ctrl.retire = 1'b1;
          state_nxt   = S_FETCH;
        end else if (timer_expire) begin
          state_nxt = S_FAULT;
        end
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
        state_nxt      = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.retire        = 1'b1;
        state_nxt          = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.retire    = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_nxt      = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (ctrl.retire) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.instr_retired = ctrl.retire;
  assign bus.fault         = (state == S_FAULT);
  assign bus.instr_count   = instr_count;

endmodule
